// File: rtl/uop_issue_unit.sv
// Registered uOP issue stage: decodes one uOP word per handshake and fans the controls out to N_CORES cores,
// holds memory uOPs on the bus for MEM_LAT cycles, flags bus contention and counts INCEND completions.
module uop_issue_unit #(
    parameter int N_CORES = 4,
    parameter int UOP_W   = 49,
    parameter int MEM_LAT = 2,
    parameter int END_W   = 4,
    localparam int CTRL_W = 71
) (
    input  logic                        CLK,
    input  logic                        RESETn,
    input  logic                        START,
    input  logic                        UOP_VALID,
    input  logic [UOP_W-1:0]            UOPS,
    input  logic [N_CORES-1:0]          CORE_MASK,
    output logic                        UOP_READY,
    output logic [N_CORES*CTRL_W-1:0]   CTRL_O,
    output logic                        BUSY,
    output logic                        ERR,
    output logic [END_W-1:0]            END_CNT,
    output logic                        DONE
);

    // Control line positions inside one core's CTRL_W slice.
    localparam int L_DREAD   = 0;
    localparam int L_IREAD   = 1;
    localparam int L_DWRITE  = 2;
    localparam int L_BUSMEM  = 3;
    localparam int L_MEMBUSD = 4;
    localparam int L_MEMBUSI = 5;
    localparam int L_TRBUS   = 6;
    localparam int L_DRBUS   = 9;
    localparam int L_ACBUS   = 13;
    localparam int L_LD      = 14;
    localparam int L_LDDR    = 16;
    localparam int L_LDIR    = 17;
    localparam int L_LDAC    = 19;
    localparam int L_INC     = 34;
    localparam int L_INCEND  = 34;
    localparam int L_RST     = 48;
    localparam int L_ALU     = 66;
    localparam int L_ADDKAC  = 70;

    localparam int N_LD  = 20;
    localparam int N_BUS = 8;
    localparam int N_INC = 9;
    localparam int N_RST = 18;

    // uOP field positions
    localparam int U_LD  = 12;
    localparam int U_BUS = 32;
    localparam int U_INC = 40;

    function automatic logic [CTRL_W-1:0] span(input int lo, input int hi);
        logic [CTRL_W-1:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++)
            m[i] = 1'b1;
        return m;
    endfunction

    localparam logic [CTRL_W-1:0]         HOLD_LINES = span(L_DREAD, L_ACBUS);
    localparam logic [CTRL_W-1:0]         RST_LINES  = span(L_RST, L_RST + N_RST - 1);
    localparam logic [N_CORES*CTRL_W-1:0] HOLD_REP   = {N_CORES{HOLD_LINES}};
    localparam logic [N_CORES*CTRL_W-1:0] RST_REP    = {N_CORES{RST_LINES}};
    localparam logic [3:0]                HOLD_INIT  = 4'(MEM_LAT - 1);
    localparam logic [END_W-1:0]          END_MAX    = '1;
    localparam logic [END_W-1:0]          END_TARGET = END_W'(N_CORES);

    function automatic logic [CTRL_W-1:0] decode(input logic [48:0] u);
        logic [CTRL_W-1:0] c;
        c = '0;
        for (int j = 0; j < N_LD; j++)
            c[L_LD + j] = u[U_LD + j];
        for (int j = 0; j < N_BUS; j++)
            c[L_TRBUS + j] = u[U_BUS + j];
        for (int j = 0; j < N_INC; j++)
            c[L_INC + j] = u[U_INC + j];
        // Memory uOPs: DREAD/IREAD land in DR/IR, DWRITE stores DR.
        c[L_DREAD]   = u[0];
        c[L_MEMBUSD] = u[0];
        c[L_LDDR]    |= u[0];
        c[L_IREAD]   = u[1];
        c[L_MEMBUSI] = u[1];
        c[L_LDIR]    |= u[1];
        c[L_DWRITE]  = u[2];
        c[L_BUSMEM]  = u[2];
        c[L_DRBUS]   |= u[2];
        // ALU group: ADD SUB AND OR XOR take TR as operand; all ALU ops load AC.
        c[L_TRBUS]   |= |u[7:3];
        c[L_LDAC]    |= |u[11:3];
        c[L_ALU + 0] = u[3] | u[5] | u[7] | u[9];
        c[L_ALU + 1] = u[3] | u[4] | u[8] | u[9];
        c[L_ALU + 2] = u[6] | u[7] | u[8] | u[9];
        c[L_ALU + 3] = u[10];
        c[L_ADDKAC]  = u[11];
        return c;
    endfunction

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    state_t                      state;
    logic [3:0]                  hold_cnt;
    logic [N_CORES*CTRL_W-1:0]   ctrl_q;
    logic                        err_q;
    logic [END_W-1:0]            end_q;
    logic                        done_q;

    logic [CTRL_W-1:0]           dec;
    logic [N_CORES*CTRL_W-1:0]   issue_word;
    logic                        is_mem;
    logic                        contend;
    logic                        accept;

    assign dec     = decode(UOPS[48:0]);
    assign is_mem  = |UOPS[2:0];
    assign contend = $countones(dec[L_ACBUS:L_MEMBUSD]) > 1;

    // hold_cnt counts the held cycles still to come; the last held cycle may accept the next word.
    assign UOP_READY = (state != HOLD) | (hold_cnt == 4'd0);
    assign accept    = UOP_VALID & UOP_READY;

    always_comb begin
        issue_word = '0;
        for (int k = 0; k < N_CORES; k++)
            issue_word[k*CTRL_W +: CTRL_W] = dec & {CTRL_W{CORE_MASK[k]}};
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state    <= IDLE;
            hold_cnt <= 4'd0;
            ctrl_q   <= '0;
            err_q    <= 1'b0;
            end_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            if (accept && contend) begin
                state    <= IDLE;
                hold_cnt <= 4'd0;
                ctrl_q   <= '0;
            end else if (accept) begin
                ctrl_q <= issue_word;
                if (is_mem && MEM_LAT > 1) begin
                    state    <= HOLD;
                    hold_cnt <= HOLD_INIT;
                end else begin
                    state    <= ISSUE;
                    hold_cnt <= 4'd0;
                end
            end else if (state == HOLD && hold_cnt != 4'd0) begin
                ctrl_q   <= ctrl_q & HOLD_REP;
                hold_cnt <= hold_cnt - 4'd1;
            end else begin
                state    <= IDLE;
                hold_cnt <= 4'd0;
                ctrl_q   <= '0;
            end

            // START has priority over events issued in the same cycle.
            if (START)
                err_q <= 1'b0;
            else if (accept && contend)
                err_q <= 1'b1;

            if (START)
                end_q <= '0;
            else if (accept && !contend && dec[L_INCEND] && end_q != END_MAX)
                end_q <= end_q + 1'b1;

            done_q <= START ? 1'b0 : (end_q == END_TARGET);
        end
    end

    assign CTRL_O  = ctrl_q | (RST_REP & {(N_CORES*CTRL_W){~RESETn}});
    assign BUSY    = (state != IDLE);
    assign ERR     = err_q;
    assign END_CNT = end_q;
    assign DONE    = done_q;

endmodule

// File: tb/tb_uop_issue_unit.sv
// Bench for uop_issue_unit: table-driven single words, hand sequences for hold/reset/contention/END,
// then a random stream against a cycle-numbered reference model.
module tb_uop_issue_unit;
    localparam int N   = 4;
    localparam int LAT = 3;
    localparam int CW  = 71;
    localparam int W   = N * CW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          valid = 1'b0;
    logic [48:0]   uops = '0;
    logic [N-1:0]  mask = '0;
    logic          ready, busy, err, done;
    logic [3:0]    end_cnt;
    logic [W-1:0]  ctrl;

    int total = 0;
    int bad   = 0;

    uop_issue_unit #(.N_CORES(N), .UOP_W(49), .MEM_LAT(LAT), .END_W(4)) dut (
        .CLK(clk), .RESETn(rst_n), .START(start), .UOP_VALID(valid), .UOPS(uops),
        .CORE_MASK(mask), .UOP_READY(ready), .CTRL_O(ctrl), .BUSY(busy), .ERR(err),
        .END_CNT(end_cnt), .DONE(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CW-1:0] lm(input int n);
        logic [CW-1:0] r;
        r = '0;
        r[n] = 1'b1;
        return r;
    endfunction

    function automatic logic [W-1:0] rep(input logic [CW-1:0] l, input logic [N-1:0] m);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++)
            if (m[k]) r[k*CW +: CW] = l;
        return r;
    endfunction

    // Reference decode table: one control-line set per uOP bit.
    logic [CW-1:0] dtab [49];
    logic [CW-1:0] hold_l, rst_l;

    task automatic build_tab();
        int code [9] = '{3, 2, 1, 4, 5, 6, 7, 8, 0};
        for (int b = 0; b < 49; b++) dtab[b] = '0;
        for (int j = 0; j < 20; j++) dtab[12 + j] = lm(14 + j);
        for (int j = 0; j < 8; j++)  dtab[32 + j] = lm(6 + j);
        for (int j = 0; j < 9; j++)  dtab[40 + j] = lm(34 + j);
        dtab[0] = lm(0) | lm(4) | lm(16);
        dtab[1] = lm(1) | lm(5) | lm(17);
        dtab[2] = lm(2) | lm(3) | lm(9);
        for (int op = 0; op < 9; op++) begin
            dtab[3 + op] = lm(19);
            if (op < 5) dtab[3 + op] |= lm(6);
            for (int i = 0; i < 4; i++)
                if (code[op] & (1 << i)) dtab[3 + op] |= lm(66 + i);
        end
        dtab[11] |= lm(70);
        hold_l = '0;
        rst_l  = '0;
        for (int i = 0; i <= 13; i++) hold_l |= lm(i);
        for (int i = 48; i <= 65; i++) rst_l |= lm(i);
    endtask

    function automatic logic [CW-1:0] mdec(input logic [48:0] u);
        logic [CW-1:0] r;
        r = '0;
        for (int b = 0; b < 49; b++)
            if (u[b]) r |= dtab[b];
        return r;
    endfunction

    typedef struct {
        logic [48:0]   u;
        logic [N-1:0]  m;
        logic [CW-1:0] lines;
        logic          e;
    } vec_t;

    vec_t vt [9];

    // Reference model state, indexed by cycle number.
    int           cyc, iss, lat, freec, m_end;
    bit           have, m_err, m_done;
    logic [W-1:0] w_full, w_hold;

    function automatic logic [48:0] rand_uop();
        logic [48:0] u;
        int r;
        u = '0;
        r = int'($urandom % 8);
        case (r)
            0: u = '0;
            5: begin u[$urandom % 3] = 1'b1; u[12 + $urandom % 20] = 1'b1; end
            6: begin u[$urandom % 49] = 1'b1; u[$urandom % 49] = 1'b1; end
            7: u = {$urandom, $urandom};
            default: u[$urandom % 49] = 1'b1;
        endcase
        return u;
    endfunction

    initial begin
        logic [CW-1:0] d;
        logic [W-1:0]  exp_ctrl;
        bit            exp_ready, exp_busy, acc, cont, nd;

        build_tab();
        vt[0] = '{49'd1 << 3, 4'b0101, lm(6) | lm(19) | lm(66) | lm(67), 1'b0};
        vt[1] = '{49'd0, 4'hF, '0, 1'b0};
        vt[2] = '{49'd1 << 10, 4'b1000, lm(19) | lm(69), 1'b0};
        vt[3] = '{49'd1 << 11, 4'hF, lm(19) | lm(70), 1'b0};
        vt[4] = '{(49'd1 << 12) | (49'd1 << 41), 4'b0011, lm(14) | lm(35), 1'b0};
        vt[5] = '{(49'd1 << 38) | (49'd1 << 37), 4'hF, '0, 1'b1};
        vt[6] = '{(49'd1 << 7) | (49'd1 << 36), 4'hF, '0, 1'b1};
        vt[7] = '{(49'd1 << 3) | (49'd1 << 4), 4'b0000, '0, 1'b0};
        vt[8] = '{(49'd1 << 8) | (49'd1 << 39), 4'b0010, lm(19) | lm(67) | lm(68) | lm(13), 1'b0};

        // Power-on reset
        #12;
        check("rst_ctrl", ctrl, rep(rst_l, 4'hF));
        check("rst_busy", busy, 1'b0);
        @(posedge clk); #1; rst_n = 1'b1;
        tick();
        check("rel_ready", ready, 1'b1);
        check("rel_ctrl", ctrl, '0);
        check("rel_err", err, 1'b0);
        check("rel_end", end_cnt, 4'd0);
        check("rel_done", done, 1'b0);

        // Single-word vectors from idle
        for (int i = 0; i < 9; i++) begin
            start = 1'b1; tick(); start = 1'b0;
            valid = 1'b1; uops = vt[i].u; mask = vt[i].m;
            tick();
            valid = 1'b0;
            check($sformatf("vec%0d_ctrl", i), ctrl, rep(vt[i].lines, vt[i].m));
            check($sformatf("vec%0d_err", i), err, vt[i].e);
            tick();
            check($sformatf("vec%0d_gone", i), ctrl, '0);
        end

        // Memory hold with back-to-back IREAD
        start = 1'b1; tick(); start = 1'b0;
        valid = 1'b1; uops = 49'd1; mask = 4'hF;
        check("mem_ready0", ready, 1'b1);
        tick(); uops = 49'd2;
        check("mem_c1", ctrl, rep(lm(0) | lm(4) | lm(16), 4'hF));
        check("mem_c1_ready", ready, 1'b0);
        check("mem_c1_busy", busy, 1'b1);
        tick();
        check("mem_c2", ctrl, rep(lm(0) | lm(4), 4'hF));
        check("mem_c2_ready", ready, 1'b0);
        tick();
        check("mem_c3", ctrl, rep(lm(0) | lm(4), 4'hF));
        check("mem_c3_ready", ready, 1'b1);
        tick(); valid = 1'b0;
        check("mem_c4", ctrl, rep(lm(1) | lm(5) | lm(17), 4'hF));
        tick();
        check("mem_c5", ctrl, rep(lm(1) | lm(5), 4'hF));
        tick();
        check("mem_c6", ctrl, rep(lm(1) | lm(5), 4'hF));
        tick();
        check("mem_c7", ctrl, '0);
        check("mem_c7_busy", busy, 1'b0);

        // Reset in the middle of a hold
        valid = 1'b1; uops = 49'd1; mask = 4'b0110;
        tick(); valid = 1'b0;
        tick();
        rst_n = 1'b0; #1;
        check("midrst_ctrl", ctrl, rep(rst_l, 4'hF));
        check("midrst_busy", busy, 1'b0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("midrel_ready", ready, 1'b1);
        check("midrel_busy", busy, 1'b0);
        check("midrel_ctrl", ctrl, '0);

        // Contention then sticky ERR
        valid = 1'b1; uops = (49'd1 << 38) | (49'd1 << 37); mask = 4'hF;
        tick();
        check("cont_ctrl", ctrl, '0);
        check("cont_err", err, 1'b1);
        check("cont_busy", busy, 1'b0);
        uops = 49'd1 << 3;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("clean_ctrl", ctrl, rep(lm(6) | lm(19) | lm(66) | lm(67), 4'hF));
            check("clean_err", err, 1'b1);
        end
        valid = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        check("start_err", err, 1'b0);

        // END counter and DONE
        valid = 1'b1; uops = 49'd1 << 40; mask = 4'hF;
        tick(); tick(); tick();
        check("end3", end_cnt, 4'd3);
        tick(); valid = 1'b0;
        check("end4", end_cnt, 4'd4);
        check("end4_done", done, 1'b0);
        tick();
        check("done_set", done, 1'b1);
        check("end4_hold", end_cnt, 4'd4);
        valid = 1'b1; start = 1'b1;
        tick(); valid = 1'b0; start = 1'b0;
        check("start_wins_end", end_cnt, 4'd0);
        check("start_wins_done", done, 1'b0);

        // Random stream against the model
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        cyc = 0; have = 0; freec = 0; iss = 0; lat = 1;
        m_err = 0; m_end = 0; m_done = 0;
        w_full = '0; w_hold = '0;
        for (int n = 0; n < 10000; n++) begin
            exp_ctrl = '0;
            if (have && cyc == iss) exp_ctrl = w_full;
            else if (have && cyc > iss && cyc < iss + lat) exp_ctrl = w_hold;
            exp_busy  = have && cyc >= iss && cyc < iss + lat;
            exp_ready = (cyc >= freec);
            check("rnd_ctrl", ctrl, exp_ctrl);
            check("rnd_ready", ready, exp_ready);
            check("rnd_busy", busy, exp_busy);
            check("rnd_err", err, m_err);
            check("rnd_end", end_cnt, 4'(m_end));
            check("rnd_done", done, m_done);

            valid = ($urandom % 4) != 0;
            mask  = 4'($urandom);
            start = ($urandom % 64) == 0;
            uops  = rand_uop();

            acc  = valid && exp_ready;
            d    = mdec(uops);
            cont = $countones(d[13:4]) > 1;
            nd   = start ? 1'b0 : (m_end == N);
            if (acc && cont) begin
                have  = 0;
                freec = cyc + 1;
                m_err = 1;
            end else if (acc) begin
                have   = 1;
                iss    = cyc + 1;
                lat    = (|uops[2:0]) ? LAT : 1;
                w_full = rep(d, mask);
                w_hold = rep(d & hold_l, mask);
                freec  = cyc + lat;
                if (d[34] && m_end < 15) m_end++;
            end
            if (start) begin
                m_end = 0;
                m_err = 0;
            end
            m_done = nd;
            tick();
            cyc++;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
